// File: rtl/cwt_fft_pkg.sv
// Shared types and fixed-point helpers for the FFT/IFFT butterfly datapaths.
// Helpers work on 64-bit signed values so one definition serves every sample width.
package cwt_fft_pkg;

  localparam int DEFAULT_BITS = 16;

  typedef struct packed {
    logic signed [DEFAULT_BITS-1:0] r;
    logic signed [DEFAULT_BITS-1:0] i;
  } cplx_t;

  // Round half-up, then arithmetic shift right by k; k = 0 passes the value through.
  function automatic longint round_shift(input longint x, input int k);
    if (k <= 0) return x;
    return (x + (longint'(1) <<< (k - 1))) >>> k;
  endfunction

  // Clamp to the signed range of a bits-wide two's complement word.
  function automatic longint sat_bits(input longint x, input int bits);
    longint hi;
    longint lo;
    hi = (longint'(1) <<< (bits - 1)) - 1;
    lo = -hi - 1;
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

endpackage

// File: rtl/cmul_conj_pipe.sv
// Registered complex multiply of d by the conjugate of w; one cycle of latency, held when en=0.
// Result width DW+TW+1 holds the full sum of two products without overflow.
module cmul_conj_pipe #(
  parameter int DW = 17,
  parameter int TW = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic signed [DW-1:0]  d_r,
  input  logic signed [DW-1:0]  d_i,
  input  logic signed [TW-1:0]  w_r,
  input  logic signed [TW-1:0]  w_i,
  output logic signed [DW+TW:0] p_r,
  output logic signed [DW+TW:0] p_i
);

  localparam int PW = DW + TW + 1;

  // (d_r + j d_i)(w_r - j w_i) = (d_r w_r + d_i w_i) + j(d_i w_r - d_r w_i)
  // NOTE: product registers are reset too, so nothing stale is visible after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p_r <= '0;
      p_i <= '0;
    end else if (en) begin
      p_r <= (PW'(d_r) * PW'(w_r)) + (PW'(d_i) * PW'(w_i));
      p_i <= (PW'(d_i) * PW'(w_r)) - (PW'(d_r) * PW'(w_i));
    end
  end

endmodule

// File: rtl/ifft_butterfly_pipe.sv
// Three-stage radix-2 DIF inverse butterfly: out1 = (a+b)>>S, out2 = ((a-b)*conj(W))>>S,
// rounded half-up and saturated, under valid/ready flow control with a global stage enable.
module ifft_butterfly_pipe
  import cwt_fft_pkg::*;
#(
  parameter int BITS  = 16,
  parameter int SCALE = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic signed [BITS-1:0] a_r,
  input  logic signed [BITS-1:0] a_i,
  input  logic signed [BITS-1:0] b_r,
  input  logic signed [BITS-1:0] b_i,
  input  logic signed [BITS-1:0] tw_r,
  input  logic signed [BITS-1:0] tw_i,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic signed [BITS-1:0] out1_r,
  output logic signed [BITS-1:0] out1_i,
  output logic signed [BITS-1:0] out2_r,
  output logic signed [BITS-1:0] out2_i,
  output logic                   ovf
);

  localparam int SW = BITS + 1;
  localparam int PW = 2 * BITS + 2;
  localparam int K  = BITS - 1 + SCALE;

  logic en;
  logic v1, v2;
  logic signed [SW-1:0]   s1_r, s1_i, d1_r, d1_i;
  logic signed [SW-1:0]   s2_r, s2_i;
  logic signed [BITS-1:0] w1_r, w1_i;
  logic signed [PW-1:0]   p2_r, p2_i;
  longint rs1_r, rs1_i, rs2_r, rs2_i;

  // The whole pipe advances together; bubbles travel with the data.
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1   <= 1'b0;
      s1_r <= '0;
      s1_i <= '0;
      d1_r <= '0;
      d1_i <= '0;
      w1_r <= '0;
      w1_i <= '0;
    end else if (en) begin
      v1   <= in_valid;
      s1_r <= SW'(a_r) + SW'(b_r);
      s1_i <= SW'(a_i) + SW'(b_i);
      d1_r <= SW'(a_r) - SW'(b_r);
      d1_i <= SW'(a_i) - SW'(b_i);
      w1_r <= tw_r;
      w1_i <= tw_i;
    end
  end

  cmul_conj_pipe #(
    .DW (SW),
    .TW (BITS)
  ) u_cmul (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .d_r (d1_r),
    .d_i (d1_i),
    .w_r (w1_r),
    .w_i (w1_i),
    .p_r (p2_r),
    .p_i (p2_i)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v2   <= 1'b0;
      s2_r <= '0;
      s2_i <= '0;
    end else if (en) begin
      v2   <= v1;
      s2_r <= s1_r;
      s2_i <= s1_i;
    end
  end

  // NOTE: every variable here is assigned on every pass, so no latch can be inferred.
  always_comb begin
    rs1_r = round_shift(longint'(s2_r), SCALE);
    rs1_i = round_shift(longint'(s2_i), SCALE);
    rs2_r = round_shift(longint'(p2_r), K);
    rs2_i = round_shift(longint'(p2_i), K);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out1_r    <= '0;
      out1_i    <= '0;
      out2_r    <= '0;
      out2_i    <= '0;
      ovf       <= 1'b0;
    end else if (en) begin
      out_valid <= v2;
      out1_r    <= BITS'(sat_bits(rs1_r, BITS));
      out1_i    <= BITS'(sat_bits(rs1_i, BITS));
      out2_r    <= BITS'(sat_bits(rs2_r, BITS));
      out2_i    <= BITS'(sat_bits(rs2_i, BITS));
      ovf       <= (sat_bits(rs1_r, BITS) != rs1_r) || (sat_bits(rs1_i, BITS) != rs1_i) ||
                   (sat_bits(rs2_r, BITS) != rs2_r) || (sat_bits(rs2_i, BITS) != rs2_i);
    end
  end

endmodule

// File: tb/tb_ifft_butterfly_pipe.sv
// Bench for ifft_butterfly_pipe: SCALE=1 and SCALE=0 instances share stimulus; a queue-based
// arithmetic model scores every valid output, and directed vectors pin literal results.
module tb_ifft_butterfly_pipe;
  import cwt_fft_pkg::*;

  localparam int BITS = 16;

  typedef logic signed [63:0] val_t;
  typedef struct packed {
    cplx_t a;
    cplx_t b;
    cplx_t w;
  } pair_t;

  logic clk = 1'b0;
  logic rst, in_valid, out_ready;
  logic signed [BITS-1:0] a_r, a_i, b_r, b_i, tw_r, tw_i;

  logic in_ready1, out_valid1, ovf1;
  logic signed [BITS-1:0] o1r_1, o1i_1, o2r_1, o2i_1;
  logic in_ready0, out_valid0, ovf0;
  logic signed [BITS-1:0] o1r_0, o1i_0, o2r_0, o2i_0;

  int n_checks = 0;
  int n_fail   = 0;
  int n_out1   = 0;
  pair_t q1[$];
  pair_t q0[$];
  bit stall1 = 1'b0;
  bit stall0 = 1'b0;

  always #5 clk = ~clk;

  ifft_butterfly_pipe #(.BITS(BITS), .SCALE(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .a_r(a_r), .a_i(a_i), .b_r(b_r), .b_i(b_i), .tw_r(tw_r), .tw_i(tw_i),
    .out_valid(out_valid1), .out_ready(out_ready),
    .out1_r(o1r_1), .out1_i(o1i_1), .out2_r(o2r_1), .out2_i(o2i_1), .ovf(ovf1)
  );

  ifft_butterfly_pipe #(.BITS(BITS), .SCALE(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
    .a_r(a_r), .a_i(a_i), .b_r(b_r), .b_i(b_i), .tw_r(tw_r), .tw_i(tw_i),
    .out_valid(out_valid0), .out_ready(out_ready),
    .out1_r(o1r_0), .out1_i(o1i_0), .out2_r(o2r_0), .out2_i(o2i_0), .ovf(ovf0)
  );

  task automatic check(input string name, input val_t act, input val_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic: exact integers, floor division for rounding, explicit clamp.
  function automatic longint floor_div(input longint x, input longint den);
    if (x >= 0) return x / den;
    return -((-x + den - 1) / den);
  endfunction

  function automatic longint rnd(input longint x, input int k);
    longint den;
    den = 1;
    if (k == 0) return x;
    for (int i = 0; i < k; i++) den = den * 2;
    return floor_div(x + den / 2, den);
  endfunction

  function automatic longint clamp16(input longint x);
    if (x > 32767) return 32767;
    if (x < -32768) return -32768;
    return x;
  endfunction

  function automatic bit clips(input longint x);
    return (x > 32767) || (x < -32768);
  endfunction

  task automatic cmp_model(input string tag, input pair_t p, input int scale,
                           input val_t g1r, input val_t g1i, input val_t g2r,
                           input val_t g2i, input val_t gov);
    longint ar, ai, br, bi, wr, wi, e1r, e1i, e2r, e2i;
    ar  = longint'($signed(p.a.r));
    ai  = longint'($signed(p.a.i));
    br  = longint'($signed(p.b.r));
    bi  = longint'($signed(p.b.i));
    wr  = longint'($signed(p.w.r));
    wi  = longint'($signed(p.w.i));
    e1r = rnd(ar + br, scale);
    e1i = rnd(ai + bi, scale);
    e2r = rnd((ar - br) * wr + (ai - bi) * wi, 15 + scale);
    e2i = rnd((ai - bi) * wr - (ar - br) * wi, 15 + scale);
    check({tag, "_out1_r"}, g1r, clamp16(e1r));
    check({tag, "_out1_i"}, g1i, clamp16(e1i));
    check({tag, "_out2_r"}, g2r, clamp16(e2r));
    check({tag, "_out2_i"}, g2i, clamp16(e2i));
    check({tag, "_ovf"}, gov,
          val_t'(clips(e1r) || clips(e1i) || clips(e2r) || clips(e2i)));
  endtask

  // Scoreboard bookkeeping at the active edge.
  always @(posedge clk) begin
    if (rst === 1'b1) begin
      if (out_valid1 && out_ready && q1.size() > 0) begin
        void'(q1.pop_front());
        n_out1++;
      end
      if (out_valid0 && out_ready && q0.size() > 0) void'(q0.pop_front());
      if (in_valid && in_ready1) q1.push_back({a_r, a_i, b_r, b_i, tw_r, tw_i});
      if (in_valid && in_ready0) q0.push_back({a_r, a_i, b_r, b_i, tw_r, tw_i});
      stall1 = out_valid1 && !out_ready;
      stall0 = out_valid0 && !out_ready;
    end
  end

  // Output comparison on the opposite edge.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      check("spurious_s1", val_t'(out_valid1 && q1.size() == 0), 0);
      check("spurious_s0", val_t'(out_valid0 && q0.size() == 0), 0);
      if (stall1) check("stall_hold_s1", val_t'(out_valid1), 1);
      if (stall0) check("stall_hold_s0", val_t'(out_valid0), 1);
      if (out_valid1 && q1.size() > 0)
        cmp_model("s1", q1[0], 1, val_t'(o1r_1), val_t'(o1i_1), val_t'(o2r_1),
                  val_t'(o2i_1), val_t'(ovf1));
      if (out_valid0 && q0.size() > 0)
        cmp_model("s0", q0[0], 0, val_t'(o1r_0), val_t'(o1i_0), val_t'(o2r_0),
                  val_t'(o2i_0), val_t'(ovf0));
    end
  end

  task automatic set_pair(input int ar, input int ai, input int br, input int bi,
                          input int wr, input int wi);
    a_r  = BITS'(ar);
    a_i  = BITS'(ai);
    b_r  = BITS'(br);
    b_i  = BITS'(bi);
    tw_r = BITS'(wr);
    tw_i = BITS'(wi);
  endtask

  // One isolated pair: checks 3-clock latency, then literal results of both instances.
  task automatic one_pair(input string tag,
                          input int ar, input int ai, input int br, input int bi,
                          input int wr, input int wi,
                          input int e1r, input int e1i, input int e2r, input int e2i,
                          input int eov, input int z1r, input int zov);
    set_pair(ar, ai, br, bi, wr, wi);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({tag, "_lat1"}, val_t'(out_valid1), 0);
    @(posedge clk); #1;
    check({tag, "_lat2"}, val_t'(out_valid1), 0);
    @(posedge clk); #1;
    check({tag, "_lat3_s1"}, val_t'(out_valid1), 1);
    check({tag, "_lat3_s0"}, val_t'(out_valid0), 1);
    check({tag, "_lit_out1_r"}, val_t'(o1r_1), val_t'(e1r));
    check({tag, "_lit_out1_i"}, val_t'(o1i_1), val_t'(e1i));
    check({tag, "_lit_out2_r"}, val_t'(o2r_1), val_t'(e2r));
    check({tag, "_lit_out2_i"}, val_t'(o2i_1), val_t'(e2i));
    check({tag, "_lit_ovf"}, val_t'(ovf1), val_t'(eov));
    check({tag, "_lit_s0_out1_r"}, val_t'(o1r_0), val_t'(z1r));
    check({tag, "_lit_s0_ovf"}, val_t'(ovf0), val_t'(zov));
    @(posedge clk); #1;
    check({tag, "_drained"}, val_t'(out_valid1), 0);
  endtask

  initial begin
    int j;
    int acc;
    int cyc;
    int base;
    bit pending;
    bit fire;

    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    set_pair(0, 0, 0, 0, 0, 0);
    #1;
    check("rst_out_valid", val_t'(out_valid1), 0);
    check("rst_in_ready", val_t'(in_ready1), 1);
    check("rst_out1_r", val_t'(o1r_1), 0);
    check("rst_out2_i", val_t'(o2i_1), 0);
    check("rst_ovf", val_t'(ovf1), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    check("idle_in_ready", val_t'(in_ready1), 1);

    // Directed vectors with hand-derived results.
    one_pair("w_one",   1000, 0, 200, 0, 32767, 0,       600, 0, 400, 0, 0, 1200, 0);
    one_pair("w_negj",  1000, 0, 200, 0, 0, -32768,      600, 0, 0, 400, 0, 1200, 0);
    one_pair("sat_sum", 32767, 0, 1, 0, 32767, 0,        16384, 0, 16383, 0, 0, 32767, 1);
    one_pair("w_min",   32767, -32768, -32768, 32767, -32768, -32768,
             0, 0, 0, 32767, 1, -1, 1);

    // Stream 8 pairs back to back with out_ready low in cycles 4..9.
    base = n_out1;
    j = 0;
    for (int k = 0; k < 40 && (j < 8 || q1.size() > 0); k++) begin
      out_ready = !(k >= 4 && k <= 9);
      in_valid  = (j < 8);
      set_pair(j * 1000 - 3000, j * 77, 500 - j * 250, -j * 10,
               32767 - j * 4000, j * 3000 - 12000);
      #1;
      check("stall_in_ready", val_t'(in_ready1), val_t'(!(k >= 4 && k <= 9)));
      fire = in_valid && in_ready1;
      @(posedge clk); #1;
      if (fire) j++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("stream_count", val_t'(n_out1 - base), 8);
    check("stream_empty", val_t'(q1.size()), 0);

    // Asynchronous reset with pairs in flight, asserted mid-clock.
    for (int k = 0; k < 4; k++) begin
      set_pair(k * 111, -k * 222, k * 333, 44, 20000, -k * 5000);
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("pre_rst_valid", val_t'(out_valid1), 1);
    #2;
    rst = 1'b0;
    q1.delete();
    q0.delete();
    stall1 = 1'b0;
    stall0 = 1'b0;
    #1;
    check("midrst_out_valid_s1", val_t'(out_valid1), 0);
    check("midrst_out_valid_s0", val_t'(out_valid0), 0);
    check("midrst_out1_r", val_t'(o1r_1), 0);
    check("midrst_out2_r", val_t'(o2r_1), 0);
    check("midrst_ovf", val_t'(ovf1), 0);
    check("midrst_in_ready", val_t'(in_ready1), 1);
    @(posedge clk); #1;
    check("midrst_hold", val_t'(out_valid1), 0);
    rst = 1'b1;
    one_pair("post_rst", 300, -200, -100, 50, 23170, -23170, 100, -75, 230, 53, 0, 200, 0);

    // Random traffic: random in_valid/out_ready, data held while a pair waits.
    acc     = 0;
    cyc     = 0;
    pending = 1'b0;
    while (acc < 10000 && cyc < 60000) begin
      out_ready = ($urandom_range(3) != 0);
      if (!pending) begin
        in_valid = ($urandom_range(3) != 0);
        {a_r, a_i}   = $urandom;
        {b_r, b_i}   = $urandom;
        {tw_r, tw_i} = $urandom;
      end
      #1;
      fire = in_valid && in_ready1;
      @(posedge clk); #1;
      if (fire) acc++;
      pending = in_valid && !fire;
      cyc++;
    end
    check("rand_budget", val_t'(acc), 10000);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 20 && (q1.size() > 0 || q0.size() > 0); k++) begin
      @(posedge clk); #1;
    end
    check("rand_drain_s1", val_t'(q1.size()), 0);
    check("rand_drain_s0", val_t'(q0.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
